rr_stream_mux: RTL

Parametrised N-channel streaming multiplexer with valid/ready handshakes on every input and on the output. It generalises the 4:1 select mux. The select lines are replaced by an internal arbiter with two modes: fixed-priority and round-robin. A single registered output stage gives 1-cycle latency and full throughput. It sits between multiple producers and one shared consumer, such as a bus or UART TX.

---
 rtl/rr_stream_mux.sv | 79 +++++++
 1 files changed

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with a fixed-priority or round-robin arbiter
// feeding a single registered output stage (1-cycle latency, full throughput).
module rr_stream_mux #(
   parameter int N_CH = 4,
   parameter int DATA_W = 8,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CH*DATA_W-1:0]   in_data,
   input  logic [N_CH-1:0]          in_valid,
   output logic [N_CH-1:0]          in_ready,
   input  logic                     mode,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_sel,
   output logic                     out_valid,
   input  logic                     out_ready
);

   logic              load_en;
   logic              any_valid;
   logic              hi_found;
   logic              take;
   logic [SEL_W-1:0]  lo_idx;
   logic [SEL_W-1:0]  hi_idx;
   logic [SEL_W-1:0]  grant;
   logic [SEL_W-1:0]  ptr;
   logic [DATA_W-1:0] grant_data;

   assign load_en = !out_valid || out_ready;
   assign take    = rst_n && load_en && any_valid;

   // Round robin is the lowest valid index at or above ptr, wrapping to the lowest valid overall.
   always_comb begin
      any_valid = 1'b0;
      hi_found  = 1'b0;
      lo_idx    = '0;
      hi_idx    = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            any_valid = 1'b1;
            lo_idx    = SEL_W'(i);
            if (i >= int'(ptr)) begin
               hi_found = 1'b1;
               hi_idx   = SEL_W'(i);
            end
         end
      end
      grant = (mode && hi_found) ? hi_idx : lo_idx;
   end

   always_comb begin
      grant_data = '0;
      in_ready   = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (grant == SEL_W'(i)) begin
            grant_data  = in_data[i*DATA_W +: DATA_W];
            in_ready[i] = take;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (take) begin
         out_valid <= 1'b1;
         out_data  <= grant_data;
         out_sel   <= grant;
         ptr       <= (grant == SEL_W'(N_CH - 1)) ? '0 : grant + SEL_W'(1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
